seq_divider: RTL and testbench

Sequential restoring divider built around a shared ripple subtractor. It computes the unsigned quotient and remainder of two WIDTH-bit operands by iterated shift-and-subtract, one subtraction per clock. A small FSM sequences the shared subtractor across WIDTH iterations. It sits beside the combinational adder/subtractor blocks as the first clocked arithmetic controller, with results shown on the number display.

---
 rtl/div_pkg.sv | 12 +
 rtl/ripple_sub.sv | 24 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ripple_sub.sv
// N-bit ripple-carry subtractor: diff = a + ~b + 1, cout=1 means no borrow.
module ripple_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);

    logic [N:0]   w_c;
    logic [N-1:0] w_bn;

    assign w_c[0] = 1'b1;
    assign w_bn   = ~b;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]  = a[i] ^ w_bn[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & w_bn[i]) | (w_c[i] & (a[i] ^ w_bn[i]));
    end

    assign cout = w_c[N];

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider, one iteration per clock over a shared subtractor.
// Divide by zero returns quotient all ones, remainder = a, div_zero = 1.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;

    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_d;
    logic             w_cout;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_accept;
    logic             w_b_zero;
    logic             w_unused_dmsb;

    // Partial remainder extended by the next dividend bit; the top bit matters when R >= 2^(WIDTH-1).
    assign w_t = {r_r, r_q[WIDTH-1]};

    ripple_sub #(.N(WIDTH + 1)) u_sub (
        .a    (w_t),
        .b    ({1'b0, r_b}),
        .diff (w_d),
        .cout (w_cout)
    );

    assign w_unused_dmsb = w_d[WIDTH];
    assign w_r_next      = w_cout ? w_d[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_q_next      = {r_q[WIDTH-2:0], w_cout};
    assign w_accept      = (r_state == IDLE) && start;
    assign w_b_zero      = (b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_b    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            if (w_b_zero) begin
                r_quot <= '1;
                r_rem  <= a;
                r_dz   <= 1'b1;
            end else begin
                r_q   <= a;
                r_b   <= b;
                r_r   <= '0;
                r_cnt <= CNT_W'(WIDTH - 1);
            end
        end else if (r_state == RUN) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (r_cnt == '0) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
                r_dz   <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and table-driven checks for seq_divider, plus an exhaustive 4-bit sweep.
module tb_seq_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int n_pass;
    int n_total;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        logic             edz;
        string            nm;
    } vec_t;

    vec_t vecs[6];

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_div(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edz, input string nm);
        int cyc;
        int nbusy;
        int exp_lat;
        exp_lat = (vb == 0) ? 1 : WIDTH + 1;
        start = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cyc   = 1;
        nbusy = busy ? 1 : 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
        end
        chk({nm, " latency"}, cyc, exp_lat);
        chk({nm, " busy cycles"}, nbusy, exp_lat);
        chk({nm, " quotient"}, int'(quotient), int'(eq));
        chk({nm, " remainder"}, int'(remainder), int'(er));
        chk({nm, " div_zero"}, int'(div_zero), int'(edz));
        @(negedge clk);
        chk({nm, " done pulse width"}, int'(done), 0);
        chk({nm, " busy after done"}, int'(busy), 0);
        chk({nm, " quotient held"}, int'(quotient), int'(eq));
    endtask

    initial begin
        int ndone;
        int qa;
        int qb;
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, "13/4"};
        vecs[1] = '{4'd15, 4'd9,  4'd1,  4'd6, 1'b0, "15/9"};
        vecs[2] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, "15/15"};
        vecs[3] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, "3/7"};
        vecs[4] = '{4'd5,  4'd0,  4'd15, 4'd5, 1'b1, "5/0"};
        vecs[5] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, "8/2"};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset div_zero", int'(div_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table vectors
        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].nm);
        end

        // start held high: one division per IDLE visit, operand changes during RUN ignored
        start = 1'b1;
        a = 4'd12;
        b = 4'd5;
        ndone = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                a = 4'd1;
                b = 4'd1;
            end
            if (done) ndone++;
            if (cyc == 5) begin
                chk("held start done@5", int'(done), 1);
                chk("held start quotient", int'(quotient), 2);
                chk("held start remainder", int'(remainder), 2);
                a = 4'd12;
                b = 4'd5;
            end
            if (cyc == 6) chk("held start idle gap", int'(busy), 0);
            if (cyc == 7) begin
                chk("held start re-accept", int'(busy), 1);
                start = 1'b0;
                a = 4'd0;
                b = 4'd0;
            end
            if (cyc == 11) begin
                chk("held start 2nd done@11", int'(done), 1);
                chk("held start 2nd quotient", int'(quotient), 2);
                chk("held start 2nd remainder", int'(remainder), 2);
            end
        end
        chk("held start done count", ndone, 2);
        chk("held start final idle", int'(busy), 0);

        // Reset two cycles into a 14/3 run
        start = 1'b1;
        a = 4'd14;
        b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun rst busy", int'(busy), 0);
        chk("midrun rst done", int'(done), 0);
        chk("midrun rst quotient", int'(quotient), 0);
        chk("midrun rst remainder", int'(remainder), 0);
        chk("midrun rst div_zero", int'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrun rst no activity", ndone, 0);
        run_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, "14/3 after rst");

        // Exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            qa = i / 16;
            qb = i % 16;
            if (qb == 0) begin
                run_div(WIDTH'(qa), WIDTH'(qb), 4'hF, WIDTH'(qa), 1'b1, $sformatf("sweep %0d/%0d", qa, qb));
            end else begin
                run_div(WIDTH'(qa), WIDTH'(qb), WIDTH'(qa / qb), WIDTH'(qa % qb), 1'b0,
                        $sformatf("sweep %0d/%0d", qa, qb));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
